// File: rtl/cpu_pkg.sv
// Shared types and constants for the CS220 datapath.
// Fetch-stage widths, the halt opcode and the fetch FSM states.
package cpu_pkg;

  localparam int PC_W = 9;
  localparam int IW = 32;
  localparam int MEM_DEPTH = 1 << PC_W;
  localparam int CNT_W = 16;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam logic [OP_HI-OP_LO:0] HALT_OP = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [IW-1:0] w);
    return w[OP_HI:OP_LO] == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port for program load,
// one asynchronous read port feeding the fetch output register.
module instr_mem
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [IW-1:0]   wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [IW-1:0]   rdata
);

  logic [IW-1:0] mem [MEM_DEPTH];

  // program load write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, next-PC mux, registered instruction output,
// start/halt control and a saturating fetch counter.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [PC_W-1:0]  load_addr,
  input  logic [IW-1:0]    load_data,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [IW-1:0]    instr,
  output logic [PC_W-1:0]  pc,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [IW-1:0]    instr_q;
  logic [PC_W-1:0]  pc_q;
  logic             valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PC_W-1:0]  fetch_addr;
  logic [IW-1:0]    rdata;
  logic             take;
  logic             first;
  logic             halt_set;
  logic             mem_we;
  logic             cur_halt;

  assign cur_halt = is_halt(instr_q);

  // loads are only safe while nothing is being fetched
  assign mem_we = load_en && (state_q != RUN);

  instr_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: a halt opcode retires only when not stalled
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!stall && cur_halt) state_d = HALT;
      end
      HALT: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // fetch decision; halt beats a redirect on the same instruction
  always_comb begin
    fetch_addr = pc_q + 1'b1;
    take = 1'b0;
    first = 1'b0;
    halt_set = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          fetch_addr = '0;
          take = 1'b1;
          first = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cur_halt) begin
            halt_set = 1'b1;
          end else begin
            take = 1'b1;
            if (branch_taken) begin
              fetch_addr = branch_target;
            end
          end
        end
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

  // output registers and saturating counter
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q <= '0;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (take) begin
        instr_q <= rdata;
        pc_q <= fetch_addr;
        valid_q <= 1'b1;
        halted_q <= 1'b0;
        if (first) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (halt_set) begin
        valid_q <= 1'b0;
        halted_q <= 1'b1;
      end
    end
  end

  assign instr = instr_q;
  assign pc = pc_q;
  assign instr_valid = valid_q;
  assign halted = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table plus a counter
// saturation sequence, checked through an expectation queue.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [8:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic [31:0] instr;
  logic [8:0]  pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        st;
    logic        bt;
    logic [8:0]  tgt;
    logic        le;
    logic [8:0]  la;
    logic [31:0] ld;
    logic [8:0]  pc;
    logic [31:0] in;
    logic        v;
    logic        h;
    logic [15:0] c;
  } vec_t;

  typedef struct {
    int          id;
    logic [8:0]  pc;
    logic [31:0] in;
    logic        v;
    logic        h;
    logic [15:0] c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    input logic r, input logic s, input logic st, input logic bt,
    input int tgt, input logic le, input int la, input logic [31:0] ld,
    input int epc, input logic [31:0] ein, input logic ev,
    input logic eh, input int ec);
    vec_t x;
    x.r = r; x.s = s; x.st = st; x.bt = bt;
    x.tgt = tgt[8:0]; x.le = le; x.la = la[8:0]; x.ld = ld;
    x.pc = epc[8:0]; x.in = ein; x.v = ev; x.h = eh;
    x.c = ec[15:0];
    return x;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.r; start = x.s; stall = x.st;
    branch_taken = x.bt; branch_target = x.tgt;
    load_en = x.le; load_addr = x.la; load_data = x.ld;
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    chk("pc", e.id, 32'(pc), 32'(e.pc));
    chk("instr", e.id, instr, e.in);
    chk("instr_valid", e.id, 32'(instr_valid), 32'(e.v));
    chk("halted", e.id, 32'(halted), 32'(e.h));
    chk("fetch_count", e.id, 32'(fetch_count), 32'(e.c));
  endtask

  localparam logic [31:0] I0 = 32'h3908001C;
  localparam logic [31:0] I1 = 32'h3D0C001C;
  localparam logic [31:0] I2 = 32'h430C001C;
  localparam logic [31:0] HL = 32'hFC000000;
  localparam logic [31:0] T28 = 32'h12345678;
  localparam logic [31:0] T29 = 32'h00000029;
  localparam logic [31:0] T511 = 32'h0BAD0511;

  initial begin
    exp_t e;
    vec_t x;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // r s st bt tgt le la ld | pc instr v h cnt
    vecs.push_back(mk(1,0,0,0,0,  0,0,0,   0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,  0,0,0,   0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  1,0,I0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  1,1,I1,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  1,2,I2,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  1,3,HL,  0,0,0,0,0));
    // load and run to halt; halt beats redirect
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   0,I0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   1,I1,1,0,2));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   3,HL,1,0,4));
    vecs.push_back(mk(0,0,0,1,28, 0,0,0,   3,HL,0,1,4));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   3,HL,0,1,4));
    // loads accepted in HALT
    vecs.push_back(mk(0,0,0,0,0,  1,28,T28, 3,HL,0,1,4));
    vecs.push_back(mk(0,0,0,0,0,  1,29,T29, 3,HL,0,1,4));
    vecs.push_back(mk(0,0,0,0,0,  1,30,HL,  3,HL,0,1,4));
    vecs.push_back(mk(0,0,0,0,0,  1,511,T511,3,HL,0,1,4));
    // restart from HALT, start in RUN ignored, redirect
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   0,I0,1,0,1));
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   1,I1,1,0,2));
    vecs.push_back(mk(0,0,0,1,28, 0,0,0,   28,T28,1,0,3));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   29,T29,1,0,4));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   30,HL,1,0,5));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   30,HL,0,1,5));
    // stall three cycles with a held redirect
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   0,I0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   1,I1,1,0,2));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,1,1,28, 0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,1,1,28, 0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,1,1,28, 0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,0,1,28, 0,0,0,   28,T28,1,0,4));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   29,T29,1,0,5));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   30,HL,1,0,6));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   30,HL,0,1,6));
    // wrap, loads ignored in RUN, reset mid-run
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   0,I0,1,0,1));
    vecs.push_back(mk(0,0,0,1,511,0,0,0,   511,T511,1,0,2));
    vecs.push_back(mk(0,0,0,0,0,  1,1,HL,  0,I0,1,0,3));
    vecs.push_back(mk(0,0,0,0,0,  1,2,HL,  1,I1,1,0,4));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   2,I2,1,0,5));
    vecs.push_back(mk(1,0,0,0,0,  0,0,0,   0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   0,0,0,0,0));
    // replay original program after reset
    vecs.push_back(mk(0,1,0,0,0,  0,0,0,   0,I0,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   1,I1,1,0,2));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   2,I2,1,0,3));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   3,HL,1,0,4));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,   3,HL,0,1,4));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      x = vecs[i];
      drive(x);
      e.id = i; e.pc = x.pc; e.in = x.in;
      e.v = x.v; e.h = x.h; e.c = x.c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_pop();
    end

    // counter saturation: spin on address 28 via redirects
    x = mk(0,1,0,0,0, 0,0,0, 0,I0,1,0,1);
    drive(x);
    @(posedge clk);
    #1;
    chk("sat_start_count", 1000, 32'(fetch_count), 32'd1);
    for (int i = 1; i <= 65540; i++) begin
      x = mk(0,0,0,1,28, 0,0,0, 0,0,0,0,0);
      drive(x);
      @(posedge clk);
      #1;
      if (i == 65533) begin
        e.id = 1001; e.pc = 9'd28; e.in = T28;
        e.v = 1'b1; e.h = 1'b0; e.c = 16'hFFFE;
        sb.push_back(e);
        check_pop();
      end
    end
    e.id = 1002; e.pc = 9'd28; e.in = T28;
    e.v = 1'b1; e.h = 1'b0; e.c = 16'hFFFF;
    sb.push_back(e);
    check_pop();

    x = mk(1,0,0,0,0, 0,0,0, 0,0,0,0,0);
    drive(x);
    e.id = 1003; e.pc = '0; e.in = '0;
    e.v = 1'b0; e.h = 1'b0; e.c = '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the CS220 single-issue datapath. Holds the program counter and a 512-word instruction memory. Presents one 32-bit instruction per cycle, with its 9-bit address, to the downstream branch unit. Accepts that unit's taken/target redirect, so control flow changes with no bubble.

## Interface
- `PC_W`, 9: program-counter width; memory depth is 2^PC_W words.
- `IW`, 32: instruction width.
- `HALT_OP`, 6'b111111: opcode (instr[31:26]) that stops fetch.

- `clk`  in  1  rising-edge clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  write `load_data` into memory at `load_addr`.
- `load_addr`  in  PC_W  program-load address.
- `load_data`  in  IW  program-load word.
- `start`  in  1  one-cycle pulse; begin fetching at address 0.
- `stall`  in  1  downstream hold; freezes the stage.
- `branch_taken`  in  1  redirect request for the instruction currently presented.
- `branch_target`  in  PC_W  redirect address.
- `instr`  out  IW  presented instruction.
- `pc`  out  PC_W  address of `instr`.
- `instr_valid`  out  1  `instr`/`pc` are a live fetch.
- `halted`  out  1  HALT_OP has been retired from this stage.
- `fetch_count`  out  16  instructions presented since `start`, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN on `start`.
  - RUN → HALT when the presented `instr` has opcode HALT_OP and `stall`=0.
  - HALT → RUN on `start`.
  - `rst` → IDLE from any state.
- Program load:
  - Writes are accepted only in IDLE or HALT.
  - `load_en` in RUN is ignored.
  - Memory contents are not cleared by `rst`.
- Entering RUN via `start`:
  - Next cycle: `pc`=0, `instr`=mem[0], `instr_valid`=1.
  - `fetch_count` is cleared, then counts this fetch (becomes 1).
- In RUN with `stall`=0, the next fetch address is `branch_taken ? branch_target : pc+1`.
- Wrap-around: `pc` 511 + 1 → 0, modulo 2^PC_W, no flag.
- `stall`=1 in RUN:
  - `instr`, `pc`, `instr_valid`, `fetch_count` and state all hold.
  - `branch_taken` is ignored that cycle; the downstream unit holds it until `stall` drops.
- HALT: `instr_valid`=0 and `halted`=1; `instr`/`pc` hold the halt instruction.
- `start` while already in RUN is ignored.
- A HALT_OP instruction that is also redirected by `branch_taken`: HALT wins, and the redirect is dropped.

## Timing
- Reset values: `instr`=0, `pc`=0, `instr_valid`=0, `halted`=0, `fetch_count`=0, state IDLE.
- All outputs are registered.
- Memory read is asynchronous into the output register, giving 1-cycle fetch latency:
  - Inputs sampled at edge N determine the outputs after edge N.
- A redirect has zero bubble: the target instruction is presented on the cycle after `branch_taken`.
- Load-to-fetch: a word written at edge N is readable by a fetch decided at edge N+1 or later.
- `rst` mid-RUN: the next cycle shows reset values. The program is retained, and a new `start` refetches from 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W` and `IW`.
  - `HALT_OP`.
  - opcode field position [31:26].
  - the fetch FSM state enum (IDLE/RUN/HALT).
- Sub-module `instr_mem`: 2^PC_W × IW array, one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
- `instr_fetch` contains the FSM, the next-PC mux, the output registers and the counter.

## Test plan
- **Load and run:** after `rst`, load mem[0..3] = 32'h3908001C, 32'h3D0C001C, 32'h430C001C, 32'hFC000000, then pulse `start`. Required: `pc` 0,1,2,3 on consecutive cycles with those instructions. The cycle after `pc`=3, `instr_valid`=0, `halted`=1 and `fetch_count`=4.
- **Redirect:** with `pc`=1 presented, assert `branch_taken`, `branch_target`=9'd28 (mem[28]=32'h12345678). Next cycle: `pc`=28, `instr`=32'h12345678, then `pc`=29.
- **Stall:** stall for 3 cycles while `pc`=2. Required: outputs are frozen and `fetch_count` is unchanged. A `branch_taken` asserted during the stall and held until after it redirects only on the first unstalled cycle.
- **Wrap:** `branch_target`=511, where mem[511] is not HALT. Next cycles show `pc`=511 then `pc`=0.
- **Reset and load guard:**
  - Assert `rst` mid-RUN: next cycle all outputs are 0 and state is IDLE.
  - `load_en` during RUN leaves memory unchanged, which is checked by a later refetch.
  - A new `start` replays from `pc`=0 with the original program.
